alarm_seq: RTL and testbench
============================

Name: alarm_seq

Overview:
Parametrised multi-source alarm sequencer; successor to the single-input LED/buzzer alarm.
- Latches up to NUM_SRC alarm requests until acknowledged.
- Selects the highest-priority pending source and drives a coded beep cadence: source k gives k+1 beeps, then a pause.
- All timing uses clock-enable ticks from clk; there is no derived clock. Sits between the safe-box control FSM and the board LED/buzzer pins.

Parameters:
- NUM_SRC, 4: number of alarm sources (>=2); index 0 is the highest priority.
- TONE_DIV, 8000: clk cycles per buzzer half-period (tone toggle interval).
- CADENCE_DIV, 400000: clk cycles per cadence unit (one beep-on or beep-off slot).
- PAUSE_UNITS, 4: cadence units of silence after each beep group (>=1).
- TIMEOUT_UNITS, 600: cadence units of buzzer sound before auto-silence (only used with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- alarm  in  NUM_SRC  level alarm requests; sampled every cycle.
- ack  in  NUM_SRC  one-cycle clear mask for latched requests.
- mute  in  1  level; forces the buzzer to idle, LED unaffected.
- led  out  1  1 while any alarm is being sequenced.
- buzzer  out  1  active-low tone drive; idle level 1.
- active  out  1  state != IDLE.
- src_id  out  $clog2(NUM_SRC)  source currently sequenced.

Behaviour:
- Reset values: led=0, buzzer=1, active=0, src_id=0, pending=0, state=IDLE, all counters=0, tone phase=1. Reset mid-sequence aborts the sequence in the same edge.
- pending register update: pending <= (pending & ~ack) | alarm. Set wins over ack in the same cycle, so a held alarm re-latches.
- Tone counter:
  - Free-runs 0..TONE_DIV-1 only while state==BEEP_ON.
  - Tone phase toggles at the terminal count.
  - Counter and phase reload to 0/1 on entry to BEEP_ON.
- Cadence counter:
  - Counts 0..CADENCE_DIV-1 and produces a one-cycle unit tick at the terminal count.
  - Cleared on every state transition.
- FSM states: IDLE, BEEP_ON, BEEP_OFF, PAUSE.
  - IDLE: if pending!=0, next cycle go to BEEP_ON. src_id <= index of the lowest set pending bit; beep_cnt <= 0.
  - BEEP_ON: on unit tick go to BEEP_OFF.
  - BEEP_OFF: on unit tick, if beep_cnt==src_id go to PAUSE and clear pause_cnt; else beep_cnt++ and go to BEEP_ON.
  - PAUSE: on each unit tick pause_cnt++. When pause_cnt reaches PAUSE_UNITS-1 at a tick, re-arbitrate: pending!=0 gives BEEP_ON with a fresh src_id and beep_cnt=0; otherwise IDLE.
  - Any non-IDLE state with pending==0 (all acked, no alarm held) goes to IDLE on the next cycle.
  - src_id changes only at IDLE exit or at PAUSE end. A higher-priority arrival mid-group does not preempt; it is served after the current pause.
- Outputs are registered (one cycle after state/phase):
  - led = active = (state!=IDLE).
  - buzzer = (state==BEEP_ON && !mute && !silenced) ? tone phase : 1.
- Latency: alarm asserted at cycle t gives pending at t+1, active/led at t+3, first buzzer low at t+3+TONE_DIV.

Optional Feature:
- Macro ALARM_TIMEOUT_EN, when defined:
  - A timeout counter increments on every unit tick while state!=IDLE.
  - At TIMEOUT_UNITS, silenced=1 and the buzzer is held at 1; LED and sequencing continue.
  - The counter and silenced clear on return to IDLE or on reset.
- Macro not defined: silenced is constant 0; the buzzer sounds until acked or muted.

Decomposition:
- Package alarm_pkg:
  - state enum (IDLE, BEEP_ON, BEEP_OFF, PAUSE).
  - Idle-level constants (BUZZER_IDLE=1, LED_IDLE=0).
  - Priority-encoder function (lowest set bit to index).
- Sub-module alarm_tick_gen (parameter DIV; inputs clk, rst, clr, en; output tick). Instantiated for the tone divider and the cadence divider.

Test Plan (bench overrides TONE_DIV=4, CADENCE_DIV=20, PAUSE_UNITS=2, NUM_SRC=4, TIMEOUT_UNITS=12):
1. Reset -> led=0, buzzer=1, active=0, src_id=0. Assert rst for 1 cycle mid-BEEP_ON -> same values next cycle.
2. One-cycle pulse on alarm[2] -> src_id=2. Three bursts of 20 cycles each, buzzer toggling every 4 cycles, separated by 20-cycle gaps, then 40 silent cycles, then repeat.
3. alarm[3] and alarm[0] pulsed together -> src_id=0 with 1 beep per group. ack=4'b0001 during PAUSE -> next group src_id=3 with 4 beeps.
4. ack=4'b0100 in the same cycle alarm[2] is held high -> pending bit stays set and sequencing continues. Release alarm, then ack -> IDLE next cycle, buzzer=1, led=0.
5. mute=1 during BEEP_ON -> buzzer=1 one cycle later; led stays 1. mute=0 -> tone resumes.
6. With ALARM_TIMEOUT_EN and alarm[1] held -> buzzer stuck at 1 after 12 units while led=1. Without the macro -> buzzer still toggling at unit 12.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and helpers for the multi-source alarm sequencer.
// Holds the FSM state encoding, idle output levels and the source priority encoder.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BEEP_ON  = 2'd1,
    BEEP_OFF = 2'd2,
    PAUSE    = 2'd3
  } state_e;

  localparam logic BUZZER_IDLE = 1'b1;
  localparam logic LED_IDLE    = 1'b0;

  // Widest request vector the encoder accepts.
  localparam int ENC_W = 32;

  // Lowest set bit wins: index 0 is the highest-priority source.
  function automatic logic [4:0] prio_enc(input logic [ENC_W-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = ENC_W - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/alarm_tick_gen.sv
// Clock-enable divider: counts 0..DIV-1 while enabled and pulses o_tick
// for one cycle on the terminal count. i_clr has priority over i_en.
module alarm_tick_gen #(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = i_en && w_last;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alarm_seq.sv
// Multi-source alarm sequencer: latches requests, serves the highest-priority
// one with a k+1 beep cadence. Optional auto-silence under macro ALARM_TIMEOUT_EN.
module alarm_seq
  import alarm_pkg::*;
#(
  parameter int NUM_SRC       = 4,
  parameter int TONE_DIV      = 8000,
  parameter int CADENCE_DIV   = 400000,
  parameter int PAUSE_UNITS   = 4,
  parameter int TIMEOUT_UNITS = 600
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_SRC-1:0]         i_alarm,
  input  logic [NUM_SRC-1:0]         i_ack,
  input  logic                       i_mute,
  output logic                       o_led,
  output logic                       o_buzzer,
  output logic                       o_active,
  output logic [$clog2(NUM_SRC)-1:0] o_src_id
);

  localparam int            SW         = $clog2(NUM_SRC);
  localparam int            PW         = (PAUSE_UNITS > 1) ? $clog2(PAUSE_UNITS) : 1;
  localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE_UNITS - 1);

  if (NUM_SRC < 2 || NUM_SRC > ENC_W || PAUSE_UNITS < 1 || TIMEOUT_UNITS < 1 ||
      TONE_DIV < 1 || CADENCE_DIV < 1) begin : g_bad_cfg
    $error("alarm_seq: unsupported parameter set");
  end

  state_e             r_state;
  logic [NUM_SRC-1:0] r_pending;
  logic [SW-1:0]      r_src;
  logic [SW-1:0]      r_beep_cnt;
  logic [PW-1:0]      r_pause_cnt;
  logic               r_tone_ph;
  logic               r_active;
  logic               r_buzzer;

  logic               w_any;
  logic               w_goto_idle;
  logic               w_beep_on;
  logic               w_tone_tick;
  logic               w_cad_tick;
  logic               w_cad_clr;
  logic               w_silenced;
  logic [SW-1:0]      w_next_src;

  assign w_any       = |r_pending;
  assign w_goto_idle = (r_state != IDLE) && !w_any;
  assign w_beep_on   = (r_state == BEEP_ON);
  assign w_next_src  = SW'(prio_enc(ENC_W'(r_pending)));

  // Ticks only advance inside a transition on the terminal count, where the
  // divider wraps anyway; the remaining transitions need an explicit clear.
  assign w_cad_clr   = (r_state == IDLE) || w_goto_idle;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_pending <= '0;
    else       r_pending <= (r_pending & ~i_ack) | i_alarm;
  end

  alarm_tick_gen #(.DIV(TONE_DIV)) u_tone_div (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (!w_beep_on),
    .i_en   (w_beep_on),
    .o_tick (w_tone_tick)
  );

  alarm_tick_gen #(.DIV(CADENCE_DIV)) u_cad_div (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_cad_clr),
    .i_en   (r_state != IDLE),
    .o_tick (w_cad_tick)
  );

  // Phase sits at 1 outside BEEP_ON, so every beep starts from the idle level.
  always_ff @(posedge i_clk) begin
    if (i_rst || !w_beep_on) r_tone_ph <= 1'b1;
    else if (w_tone_tick)    r_tone_ph <= ~r_tone_ph;
  end

`ifdef ALARM_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT_UNITS + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_UNITS);

  logic [TW-1:0] r_to_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || r_state == IDLE)     r_to_cnt <= '0;
    else if (w_cad_tick && !w_silenced) r_to_cnt <= r_to_cnt + TW'(1);
  end

  assign w_silenced = (r_to_cnt == TO_LAST);
`else
  assign w_silenced = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_src       <= '0;
      r_beep_cnt  <= '0;
      r_pause_cnt <= '0;
      r_active    <= LED_IDLE;
      r_buzzer    <= BUZZER_IDLE;
    end else begin
      r_active <= (r_state != IDLE);
      r_buzzer <= (w_beep_on && !i_mute && !w_silenced) ? r_tone_ph : BUZZER_IDLE;
      if (w_goto_idle) begin
        r_state <= IDLE;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (w_any) begin
              r_state    <= BEEP_ON;
              r_src      <= w_next_src;
              r_beep_cnt <= '0;
            end
          end
          BEEP_ON: begin
            if (w_cad_tick) r_state <= BEEP_OFF;
          end
          BEEP_OFF: begin
            if (w_cad_tick) begin
              if (r_beep_cnt == r_src) begin
                r_state     <= PAUSE;
                r_pause_cnt <= '0;
              end else begin
                r_beep_cnt <= r_beep_cnt + SW'(1);
                r_state    <= BEEP_ON;
              end
            end
          end
          PAUSE: begin
            if (w_cad_tick) begin
              if (r_pause_cnt == PAUSE_LAST) begin
                // Only point besides IDLE exit where a new source is picked.
                r_state    <= w_any ? BEEP_ON : IDLE;
                r_src      <= w_next_src;
                r_beep_cnt <= '0;
              end else begin
                r_pause_cnt <= r_pause_cnt + PW'(1);
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_led    = r_active;
  assign o_active = r_active;
  assign o_buzzer = r_buzzer;
  assign o_src_id = r_src;

endmodule

// File: tb/tb_alarm_seq.sv
// Scoreboard bench for alarm_seq: expected outputs are queued per absolute
// cycle when stimulus is driven and compared on the falling edge.
module tb_alarm_seq;

  localparam int NS  = 4;
  localparam int TD  = 4;
  localparam int CD  = 20;
  localparam int PU  = 2;
  localparam int TU  = 12;
  localparam int NOM = 1 << 30;

  localparam int SIG_LED = 0;
  localparam int SIG_BUZ = 1;
  localparam int SIG_ACT = 2;
  localparam int SIG_SRC = 3;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          mute  = 1'b0;
  logic [NS-1:0] alarm = '0;
  logic [NS-1:0] ack   = '0;
  logic          led, buzzer, active;
  logic [1:0]    src_id;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string tag;
  } exp_t;

  exp_t q[$];
  exp_t mon_it;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_err = 0;

  alarm_seq #(
    .NUM_SRC(NS), .TONE_DIV(TD), .CADENCE_DIV(CD),
    .PAUSE_UNITS(PU), .TIMEOUT_UNITS(TU)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_alarm  (alarm),
    .i_ack    (ack),
    .i_mute   (mute),
    .o_led    (led),
    .o_buzzer (buzzer),
    .o_active (active),
    .o_src_id (src_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_of(input int sig);
    case (sig)
      SIG_LED: return {31'b0, led};
      SIG_BUZ: return {31'b0, buzzer};
      SIG_ACT: return {31'b0, active};
      default: return {30'b0, src_id};
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_it = q.pop_front();
      chk(mon_it.tag, obs_of(mon_it.sig), mon_it.val);
    end
  end

  task automatic push(input int c, input int sig, input int val, input string tag);
    exp_t e;
    e.cyc = c; e.sig = sig; e.val = val; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_idle(input int c, input string pfx);
    push(c, SIG_LED, 0, {pfx, "_led"});
    push(c, SIG_BUZ, 1, {pfx, "_buz"});
    push(c, SIG_ACT, 0, {pfx, "_act"});
  endtask

  // b: first cycle the FSM is in BEEP_ON for source s; outputs lag one cycle.
  // Outputs in [mlo,mhi] are muted; outputs from sil on are timed out.
  task automatic exp_group(input int b, input int s, input int n, input int mlo,
                           input int mhi, input int sil, input string pfx);
    int o, k, e;
    push(b, SIG_SRC, s, {pfx, "_src"});
    push(b + 1, SIG_ACT, 1, {pfx, "_act"});
    for (int t = b + 1; t <= b + n; t++) begin
      o = t - 1 - b;
      k = o % (2 * CD);
      if (o < (s + 1) * 2 * CD && k < CD) e = (((k / TD) % 2) == 0) ? 1 : 0;
      else                               e = 1;
      if (t >= mlo && t <= mhi) e = 1;
      if (t >= sil) e = 1;
      push(t, SIG_LED, 1, {pfx, "_led"});
      push(t, SIG_BUZ, e, {pfx, "_buz"});
    end
  endtask

  localparam int GRP = 2 * CD;

  initial begin
    int sil;
    // Reset state
    push(2, SIG_LED, 0, "rst_led");
    push(2, SIG_BUZ, 1, "rst_buz");
    push(2, SIG_ACT, 0, "rst_act");
    push(2, SIG_SRC, 0, "rst_src");
    at(3); rst = 1'b0;

    // Reset in the middle of BEEP_ON aborts everything, including pending
    at(6); alarm = 4'b0010; exp_group(8, 1, 9, NOM, NOM, NOM, "t1");
    at(7); alarm = '0;
    at(17); rst = 1'b1;
    push_idle(18, "t1_rst");
    push(18, SIG_SRC, 0, "t1_rst_src");
    push(20, SIG_LED, 0, "t1_post_led");
    push(21, SIG_LED, 0, "t1_post_led");
    at(18); rst = 1'b0;

    // Source 2: three beeps then pause, repeated; ack mid-beep ends it
    at(30); alarm = 4'b0100;
    exp_group(32, 2, 3 * GRP + PU * CD, NOM, NOM, NOM, "t2a");
    exp_group(192, 2, 47, NOM, NOM, NOM, "t2b");
    at(31); alarm = '0;
    at(237); ack = 4'b0100; push_idle(240, "t2_ack");
    at(238); ack = '0;

    // Simultaneous 3 and 0: 0 served first, then 3 after acking 0 in pause
    at(250); alarm = 4'b1001;
    exp_group(252, 0, GRP + PU * CD, NOM, NOM, NOM, "t3a");
    exp_group(332, 3, 192, NOM, NOM, NOM, "t3b");
    at(251); alarm = '0;
    at(302); ack = 4'b0001;
    at(303); ack = '0;
    at(522); ack = 4'b1000; push_idle(525, "t3_ack");
    at(523); ack = '0;

    // Held alarm beats a same-cycle ack; release then ack goes idle
    at(540); alarm = 4'b0100; exp_group(542, 2, 60, NOM, NOM, NOM, "t4");
    at(572); ack = 4'b0100;
    at(573); ack = '0;
    at(597); alarm = '0;
    at(600); ack = 4'b0100; push_idle(603, "t4_ack");
    at(601); ack = '0;

    // Mute forces buzzer idle one cycle later; LED unaffected
    at(620); alarm = 4'b0001; exp_group(622, 0, 72, 628, 634, NOM, "t5");
    at(621); alarm = '0;
    at(627); mute = 1'b1;
    at(634); mute = 1'b0;
    at(692); ack = 4'b0001; push_idle(695, "t5_ack");
    at(693); ack = '0;

    // Long-held alarm: silenced after TU units only with the timeout build
`ifdef ALARM_TIMEOUT_EN
    sil = 712 + 1 + TU * CD;
`else
    sil = NOM;
`endif
    at(710); alarm = 4'b0010;
    exp_group(712, 1, 120, NOM, NOM, sil, "t6a");
    exp_group(832, 1, 120, NOM, NOM, sil, "t6b");
    exp_group(952, 1, 57, NOM, NOM, sil, "t6c");
    at(1007); alarm = '0; ack = 4'b0010; push_idle(1010, "t6_ack");
    at(1008); ack = '0;

    at(1020);
    chk("sb_drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
